// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one load/store from EX/MEM, holds the
// pipeline for LATENCY cycles, commits on the edge into DONE and returns load data.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_data_i,
  output logic [31:0] Read_data_o,
  output logic        stall_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       wdata_q;
  logic              req, accept, commit;
  logic              commit_wr;
  logic [IDX_W-1:0]  commit_idx, addr_idx;
  logic [31:0]       commit_data;
  logic [31:0]       mem [DEPTH_WORDS];
  logic              unused_addr;

  assign req         = MemRead_i | MemWrite_i;
  assign addr_idx    = Address_i[IDX_W+1:2];
  assign unused_addr = ^{Address_i[31:IDX_W+2], Address_i[1:0]};
  assign dbg_state_o = state_q;

  // With LATENCY == 1 the commit edge is the acceptance edge, so the live inputs are used.
  assign commit_wr   = (state_q == S_IDLE) ? MemWrite_i   : op_wr_q;
  assign commit_idx  = (state_q == S_IDLE) ? addr_idx     : idx_q;
  assign commit_data = (state_q == S_IDLE) ? Write_data_i : wdata_q;

  assign stall_o = rst_i & (((state_q == S_IDLE) & req) | (state_q == S_BUSY));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          cnt_d  = CNT_LOAD;
          if (LATENCY > 1) begin
            state_d = S_BUSY;
          end else begin
            state_d = S_DONE;
            commit  = 1'b1;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = S_DONE;
          commit  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      Read_data_o <= '0;
      op_wr_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_o  <= (state_d == S_BUSY);
      if (accept) begin
        op_wr_q <= MemWrite_i;
        idx_q   <= addr_idx;
        wdata_q <= Write_data_i;
        if ((MemRead_i & MemWrite_i) | (Address_i[1:0] != 2'b00)) err_o <= 1'b1;
      end
      if (commit && !commit_wr) Read_data_o <= mem[commit_idx];
    end
  end

  // Array has no reset; rst_i gating keeps a held request from writing during reset.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit && commit_wr) mem[commit_idx] <= commit_data;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 4 and 1), a per-cycle
// transaction-level model on the falling edge, and directed literal checks.
module tb_dmem_responder;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  logic        clk;
  logic        rst_n      [2];
  logic        mem_read   [2];
  logic        mem_write  [2];
  logic [31:0] addr       [2];
  logic [31:0] wdata      [2];
  logic [31:0] rdata      [2];
  logic        stall      [2];
  logic        busy       [2];
  logic        err        [2];
  logic [1:0]  dbg_state  [2];

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n[0]), .MemRead_i(mem_read[0]), .MemWrite_i(mem_write[0]),
    .Address_i(addr[0]), .Write_data_i(wdata[0]), .Read_data_o(rdata[0]),
    .stall_o(stall[0]), .busy_o(busy[0]), .err_o(err[0]), .dbg_state_o(dbg_state[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n[1]), .MemRead_i(mem_read[1]), .MemWrite_i(mem_write[1]),
    .Address_i(addr[1]), .Write_data_i(wdata[1]), .Read_data_o(rdata[1]),
    .stall_o(stall[1]), .busy_o(busy[1]), .err_o(err[1]), .dbg_state_o(dbg_state[1])
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // phase: -1 = no access in flight; 1..lat = cycles since acceptance, lat is the DONE cycle.
  int          phase    [2];
  bit          m_wr     [2];
  bit          m_rd     [2];
  logic [7:0]  m_idx    [2];
  logic [31:0] m_dat    [2];
  logic [31:0] exp_rd   [2];
  bit          rd_known [2];
  bit          exp_err  [2];
  logic [31:0] mm       [2][256];
  bit          mv       [2][256];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  task automatic model_step(input int k);
    int lat;
    bit req, e_stall, e_busy;
    lat = lat_of(k);
    if (rst_n[k] !== 1'b1) begin
      phase[k] = -1; exp_rd[k] = '0; rd_known[k] = 1; exp_err[k] = 0;
      chk($sformatf("m%0d_rst_stall", k), {31'd0, stall[k]}, 32'd0);
      chk($sformatf("m%0d_rst_busy", k), {31'd0, busy[k]}, 32'd0);
      chk($sformatf("m%0d_rst_err", k), {31'd0, err[k]}, 32'd0);
      chk($sformatf("m%0d_rst_rdata", k), rdata[k], 32'd0);
      return;
    end
    req = mem_read[k] | mem_write[k];
    if (phase[k] == lat) begin
      if (m_wr[k]) begin
        mm[k][m_idx[k]] = m_dat[k];
        mv[k][m_idx[k]] = 1;
      end else begin
        exp_rd[k]   = mm[k][m_idx[k]];
        rd_known[k] = mv[k][m_idx[k]];
      end
    end
    e_stall = (phase[k] < 0) ? req : (phase[k] < lat);
    e_busy  = (phase[k] >= 1) && (phase[k] < lat);
    chk($sformatf("m%0d_stall", k), {31'd0, stall[k]}, {31'd0, e_stall});
    chk($sformatf("m%0d_busy", k), {31'd0, busy[k]}, {31'd0, e_busy});
    chk($sformatf("m%0d_err", k), {31'd0, err[k]}, {31'd0, exp_err[k]});
    if (rd_known[k]) chk($sformatf("m%0d_rdata", k), rdata[k], exp_rd[k]);
    if (phase[k] < 0) begin
      if (req) begin
        m_wr[k]  = mem_write[k];
        m_rd[k]  = mem_read[k];
        m_idx[k] = addr[k][9:2];
        m_dat[k] = wdata[k];
        if ((mem_read[k] && mem_write[k]) || (addr[k][1:0] != 2'b00)) exp_err[k] = 1;
        phase[k] = 1;
      end
    end else begin
      phase[k] = (phase[k] == lat) ? -1 : phase[k] + 1;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // ---------------- drivers ----------------
  task automatic clear_in(input int k);
    mem_read[k] = 0; mem_write[k] = 0; addr[k] = '0; wdata[k] = '0;
  endtask

  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic access(input int k, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
    mem_read[k] = r; mem_write[k] = w; addr[k] = a; wdata[k] = d;
    repeat (lat_of(k) + 1) @(posedge clk);
    #1 clear_in(k);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 0; phase[k] = -1; clear_in(k);
      for (int i = 0; i < 256; i++) mv[k][i] = 0;
    end

    // Reset held 3 cycles with a read pending: nothing may stall.
    mem_read[0] = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_stall", {31'd0, stall[0]}, 32'd0);
      chk("rst_rdata", rdata[0], 32'd0);
      chk("rst_err", {31'd0, err[0]}, 32'd0);
      chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    end
    @(posedge clk); #1 rst_n[0] = 1; rst_n[1] = 1;
    @(negedge clk);
    chk("release_stall", {31'd0, stall[0]}, 32'd1);
    repeat (LAT0 + 1) @(posedge clk);
    #1 clear_in(0);

    // Write 0xDEADBEEF to 0x10 with stall-window checks.
    mem_write[0] = 1; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    @(negedge clk); chk("wr_stall_T", {31'd0, stall[0]}, 32'd1);
    repeat (3) @(negedge clk);
    chk("wr_stall_T3", {31'd0, stall[0]}, 32'd1);
    @(negedge clk);
    chk("wr_stall_T4", {31'd0, stall[0]}, 32'd0);
    @(posedge clk); #1 clear_in(0);
    access(0, 1, 0, 32'h10, 32'h0);
    chk("rd_deadbeef", rdata[0], 32'hDEADBEEF);

    // Back-to-back writes then reads; writes must not disturb Read_data_o.
    for (int i = 0; i < 4; i++) access(0, 0, 1, 32'h40 + 32'(i * 4), 32'h01010101 * 32'(i + 1));
    chk("wr_keeps_rdata", rdata[0], 32'hDEADBEEF);
    for (int i = 3; i >= 0; i--) access(0, 1, 0, 32'h40 + 32'(i * 4), 32'h0);
    chk("b2b_last_rd", rdata[0], 32'h01010101);

    // Address change during BUSY is ignored.
    access(0, 0, 1, 32'h4, 32'hCAFE0004);
    access(0, 0, 1, 32'h8, 32'h08080808);
    mem_read[0] = 1; addr[0] = 32'h4;
    @(posedge clk); #1 addr[0] = 32'h8;
    repeat (LAT0) @(posedge clk);
    #1 clear_in(0);
    chk("busy_addr_change", rdata[0], 32'hCAFE0004);
    chk("err_still_clear", {31'd0, err[0]}, 32'd0);

    // Misaligned read returns the aligned word and flags an error.
    access(0, 0, 1, 32'h10, 32'hA5A5A5A5);
    access(0, 1, 0, 32'h13, 32'h0);
    chk("misalign_data", rdata[0], 32'hA5A5A5A5);
    chk("misalign_err", {31'd0, err[0]}, 32'd1);

    // Reset, then read+write together: write only, error set.
    rst_n[0] = 0; @(posedge clk); #1 rst_n[0] = 1;
    access(0, 1, 1, 32'h20, 32'd7);
    chk("both_err", {31'd0, err[0]}, 32'd1);
    chk("both_no_read", rdata[0], 32'd0);
    access(0, 1, 0, 32'h20, 32'h0);
    chk("both_wrote", rdata[0], 32'd7);

    // Reset during the second BUSY cycle aborts the store.
    access(0, 0, 1, 32'h8, 32'h11);
    mem_write[0] = 1; addr[0] = 32'h8; wdata[0] = 32'h55;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n[0] = 0; clear_in(0);
    @(negedge clk);
    chk("abort_stall", {31'd0, stall[0]}, 32'd0);
    chk("abort_busy", {31'd0, busy[0]}, 32'd0);
    @(posedge clk); #1 rst_n[0] = 1;
    access(0, 1, 0, 32'h8, 32'h0);
    chk("abort_old_value", rdata[0], 32'h11);

    // LATENCY 1 instance: index wraps modulo 256 words.
    mem_write[1] = 1; addr[1] = 32'h400; wdata[1] = 32'h12345678;
    @(negedge clk); chk("l1_stall_T", {31'd0, stall[1]}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("l1_stall_done", {31'd0, stall[1]}, 32'd0);
    @(posedge clk); #1 clear_in(1);
    access(1, 1, 0, 32'h0, 32'h0);
    chk("l1_wrap_data", rdata[1], 32'h12345678);
    chk("l1_err", {31'd0, err[1]}, 32'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
